// File: rtl/elem_pkg.sv
// Shared types and helpers for the element-entry controller.
package elem_pkg;

   // Controller states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      WRITE = 3'd2,
      INC   = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Field positions inside an element word (field 0 in the LSBs)
   localparam int FLD_TYPE  = 0;
   localparam int FLD_VALUE = 1;
   localparam int FLD_EXP   = 2;
   localparam int FLD_NODES = 3;

   // Bit positions of the keys inside the edge-detector vector
   localparam int KEY_GO    = 0;
   localparam int KEY_RST   = 1;
   localparam int KEY_UNDO  = 2;
   localparam int KEY_OVER  = 3;
   localparam int NUM_KEYS  = 4;

   // Upper bounds for the generic packer; callers zero-extend into these
   localparam int PACK_MAX_FIELDS = 8;
   localparam int PACK_MAX_FW     = 32;

   typedef logic [PACK_MAX_FIELDS-1:0][PACK_MAX_FW-1:0] fld_arr_t;
   typedef logic [PACK_MAX_FIELDS*PACK_MAX_FW-1:0]      elem_word_t;

   // Concatenate nf fields of fw bits each, field 0 at the bottom
   function automatic elem_word_t pack_fields(input fld_arr_t f, input int nf, input int fw);
      elem_word_t w;
      w = '0;
      for (int i = 0; i < PACK_MAX_FIELDS; i++) begin
         for (int b = 0; b < PACK_MAX_FW; b++) begin
            if (i < nf && b < fw) w[8'(i*fw + b)] = f[3'(i)][5'(b)];
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/element_entry_ctrl_key_edge.sv
// Register-and-pulse edge detector: one press per rising edge of each key.
module key_edge #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] key,
   output logic [W-1:0] press
);

   logic [W-1:0] key_q, key_d;

   // Previous key level is simply the current level one cycle later
   always_comb key_d = key;

   // Key history register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) key_q <= '0;
      else        key_q <= key_d;
   end

   assign press = key & ~key_q;

endmodule

// File: rtl/element_entry_ctrl.sv
// Element-entry controller: gathers NUM_FIELDS switch fields per element,
// packs them and writes one word per element to element RAM.
module element_entry_ctrl
   import elem_pkg::*;
#(
   parameter int DATA_W       = 10,
   parameter int FIELD_W      = 8,
   parameter int NUM_FIELDS   = 4,
   parameter int MAX_ELEMENTS = 32,
   parameter int ADDR_W       = $clog2(MAX_ELEMENTS),
   parameter int CNT_W        = $clog2(MAX_ELEMENTS+1),
   parameter int FIDX_W       = $clog2(NUM_FIELDS)
) (
   input  logic                          clk,
   input  logic                          program_reset_n,
   input  logic                          start_process,
   input  logic                          go,
   input  logic                          input_reset,
   input  logic                          input_over,
   input  logic                          undo,
   input  logic [DATA_W-1:0]             data_in,
   output logic                          end_process,
   output logic [ADDR_W-1:0]             element_addr,
   output logic [NUM_FIELDS*FIELD_W-1:0] element_data,
   output logic                          element_wren,
   output logic [CNT_W-1:0]              num_elements,
   output logic [FIDX_W-1:0]             field_idx,
   output logic [FIELD_W-1:0]            field_value,
   output logic                          full
);

   localparam int                ELEM_W   = NUM_FIELDS*FIELD_W;
   localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_ELEMENTS);
   localparam logic [FIDX_W-1:0] LAST_FLD = FIDX_W'(NUM_FIELDS-1);

   state_t                               state_q, state_d;
   logic [NUM_FIELDS-1:0][FIELD_W-1:0]   field_q, field_d;
   logic [FIDX_W-1:0]                    fidx_q, fidx_d;
   logic [CNT_W-1:0]                     cnt_q, cnt_d;
   logic                                 wren_q, wren_d;
   logic [ADDR_W-1:0]                    addr_q, addr_d;
   logic [ELEM_W-1:0]                    data_q, data_d;
   logic [NUM_KEYS-1:0]                  press;
   fld_arr_t                             fld_ext;
   logic [ELEM_W-1:0]                    packed_w;
   logic                                 unused_data;

   key_edge #(.W(NUM_KEYS)) u_key_edge (
      .clk   (clk),
      .rst_n (program_reset_n),
      .key   ({input_over, undo, input_reset, go}),
      .press (press)
   );

   // Widen the field registers into the packer's generic array
   always_comb begin
      fld_ext = '0;
      for (int i = 0; i < NUM_FIELDS; i++) fld_ext[i][FIELD_W-1:0] = field_q[i];
   end

   assign packed_w = ELEM_W'(pack_fields(fld_ext, NUM_FIELDS, FIELD_W));

   // Next-state logic; presses are only honoured in LOAD, highest priority wins
   always_comb begin
      state_d = state_q;
      field_d = field_q;
      fidx_d  = fidx_q;
      cnt_d   = cnt_q;
      wren_d  = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (start_process) begin
               state_d = LOAD;
               fidx_d  = '0;
               field_d = '0;
            end
         end
         LOAD: begin
            // A list that is already full bounces straight back to DONE
            if (cnt_q == MAX_CNT) begin
               state_d = DONE;
            end else if (press[KEY_OVER]) begin
               field_d = '0;
               fidx_d  = '0;
               state_d = DONE;
            end else if (press[KEY_RST]) begin
               field_d = '0;
               fidx_d  = '0;
            end else if (press[KEY_UNDO]) begin
               if (fidx_q != '0) begin
                  fidx_d                  = fidx_q - 1'b1;
                  field_d[fidx_q - 1'b1]  = '0;
               end else if (cnt_q != '0) begin
                  // RAM word stays; the next write simply overwrites it
                  cnt_d = cnt_q - 1'b1;
               end
            end else if (press[KEY_GO]) begin
               field_d[fidx_q] = data_in[FIELD_W-1:0];
               if (fidx_q == LAST_FLD) state_d = WRITE;
               else                    fidx_d  = fidx_q + 1'b1;
            end
         end
         WRITE: begin
            wren_d  = 1'b1;
            addr_d  = cnt_q[ADDR_W-1:0];
            data_d  = packed_w;
            state_d = INC;
         end
         INC: begin
            cnt_d   = cnt_q + 1'b1;
            field_d = '0;
            fidx_d  = '0;
            state_d = (cnt_d == MAX_CNT) ? DONE : LOAD;
         end
         DONE: begin
            if (!start_process) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset also kills an in-flight write strobe
   always_ff @(posedge clk or negedge program_reset_n) begin
      if (!program_reset_n) begin
         state_q <= IDLE;
         field_q <= '0;
         fidx_q  <= '0;
         cnt_q   <= '0;
         wren_q  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         field_q <= field_d;
         fidx_q  <= fidx_d;
         cnt_q   <= cnt_d;
         wren_q  <= wren_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // Switch bits above the field width only matter to the display layer
   assign unused_data  = ^data_in;

   assign end_process  = (state_q == DONE);
   assign element_addr = addr_q;
   assign element_data = data_q;
   assign element_wren = wren_q;
   assign num_elements = cnt_q;
   assign field_idx    = fidx_q;
   assign field_value  = data_in[FIELD_W-1:0];
   assign full         = (cnt_q == MAX_CNT);

endmodule
